// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch stage and the branch control unit.
package pc_fetch_pkg;

  // Default datapath width and reset vector.
  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Next-PC select encoding, shared with the branch control unit.
  // Code 3 is reserved and behaves like BC_PC4.
  localparam logic [1:0] BC_PC4  = 2'd0;
  localparam logic [1:0] BC_IMM  = 2'd1;
  localparam logic [1:0] BC_ALU  = 2'd2;
  localparam logic [1:0] BC_RSVD = 2'd3;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

  // A fetch target is usable only when it is word aligned.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection and alignment check for the fetch stage.
module next_pc_calc
  import pc_fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic [1:0]      sel,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Pick the target; all sums wrap modulo 2^XLEN, and JALR targets drop bit 0.
  always_comb begin
    next_pc = pc + PC_STEP;
    unique case (sel)
      BC_IMM:  next_pc = instr_pc + imm;
      BC_ALU:  next_pc = {alu_result[XLEN-1:1], 1'b0};
      default: next_pc = pc + PC_STEP;
    endcase
  end

  // Anything that is not word aligned stops the fetch stage.
  always_comb begin
    misaligned = !is_word_aligned(next_pc[1:0]);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Fetches one word at a time, holds it for decode, then steers the PC
// according to the branch select sampled on the accepting cycle.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      branch_control,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            fault_q, fault_d;
  logic            imem_req_q, imem_req_d;
  logic            instr_valid_q, instr_valid_d;

  logic [XLEN-1:0] next_pc;
  logic            next_misaligned;
  logic            accept;

  next_pc_calc #(
    .XLEN (XLEN)
  ) u_next_pc_calc (
    .pc         (pc_q),
    .instr_pc   (instr_pc_q),
    .imm        (imm),
    .alu_result (alu_result),
    .sel        (branch_control),
    .next_pc    (next_pc),
    .misaligned (next_misaligned)
  );

  // Decode hands off the held instruction only while it is actually valid.
  always_comb begin
    accept = (state_q == VALID) && instr_ready;
  end

  // Next-state and register-update logic for the fetch sequencer.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = VALID;
        end
      end
      VALID: begin
        if (accept) begin
          if (next_misaligned) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = REQ;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs are registered decodes of the state being entered.
  always_comb begin
    imem_req_d    = (state_d == REQ);
    instr_valid_d = (state_d == VALID);
  end

  // State and datapath registers; reset wins over everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fault_q       <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fault_q       <= fault_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // The fetch address is the PC itself; it is only meaningful with imem_req.
  always_comb begin
    imem_req    = imem_req_q;
    imem_addr   = pc_q;
    instr_valid = instr_valid_q;
    instr       = instr_q;
    instr_pc    = instr_pc_q;
    fetch_fault = fault_q;
  end

endmodule
